id_issue_scoreboard: RTL and testbench

Issue controller in front of the ID stage. It accepts fetched 32-bit instructions, tracks outstanding register writes in a 16-entry busy scoreboard, and holds back any instruction with a RAW or WAW hazard. Hazard-free instructions go to ID under a valid/ready handshake that follows the ID FIFO's `fifo_wr_ready` backpressure. Writeback completions clear scoreboard entries; `OP_STOP` drains the machine before the next instruction is accepted.

---
 rtl/id_issue_scoreboard.sv | 180 ++++++++++++++++++
 tb/tb_id_issue_scoreboard.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_scoreboard.sv
// id_issue_scoreboard: issue controller in front of the ID stage.
// It holds one fetched instruction, checks it against a busy-register
// scoreboard for RAW/WAW hazards, and offers it to ID when hazard-free.
// Writebacks clear scoreboard entries; OP_STOP drains all outstanding
// writes before the next instruction is accepted.
// Optional feature: define SB_WB_BYPASS_EN to let a same-cycle writeback
// resolve a hazard (CHECK) or finish a drain (DRAIN) on that edge.
//
// Handshake: a transfer on either side happens on a rising edge where
// valid and ready are both high. instr_ready is high only in IDLE.
// issue_valid is high only in ISSUE, and issue_valid/issue_instr hold
// steady until issue_ready is seen. Neither ready depends
// combinationally on the other side.
//
// Opcode encoding (mirrors defines.v):
//   MOV=0 ADD=1 SUB=2 AND=3 OR=4 NOT=5 CMP=6 MULT=7 DIV=8 OB_CHECK=9
//   VELOCITY_GUARD=10 MOVE_LEFT=11 MOVE_RIGHT=12 STOP=13 CONTINUE=14
//   15..31 are undefined and behave like "neither reads nor writes".
module id_issue_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [31:0]         instr,
  output logic                instr_ready,
  output logic                issue_valid,
  output logic [31:0]         issue_instr,
  input  logic                issue_ready,
  input  logic                wb_valid,
  input  logic [3:0]          wb_addr,
  output logic [NUM_REGS-1:0] busy_map,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic                wb_spurious,
  output logic [1:0]          fsm_state
);

  localparam logic [4:0] OP_MOV            = 5'd0;
  localparam logic [4:0] OP_ADD            = 5'd1;
  localparam logic [4:0] OP_SUB            = 5'd2;
  localparam logic [4:0] OP_AND            = 5'd3;
  localparam logic [4:0] OP_OR             = 5'd4;
  localparam logic [4:0] OP_NOT            = 5'd5;
  localparam logic [4:0] OP_CMP            = 5'd6;
  localparam logic [4:0] OP_MULT           = 5'd7;
  localparam logic [4:0] OP_DIV            = 5'd8;
  localparam logic [4:0] OP_OB_CHECK       = 5'd9;
  localparam logic [4:0] OP_VELOCITY_GUARD = 5'd10;
  localparam logic [4:0] OP_STOP           = 5'd13;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  function automatic logic writes_rd(input logic [4:0] op);
    case (op)
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_MULT, OP_DIV:
        writes_rd = 1'b1;
      default:
        writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs(input logic [4:0] op);
    case (op)
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_CMP, OP_MULT,
      OP_DIV, OP_OB_CHECK, OP_VELOCITY_GUARD:
        reads_rs = 1'b1;
      default:
        reads_rs = 1'b0;
    endcase
  endfunction

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [31:0]         hold;
  logic [NUM_REGS-1:0] busy;

  logic [4:0]          hold_op;
  logic [3:0]          hold_rd;
  logic [3:0]          hold_rs1;
  logic [3:0]          hold_rs2;
  logic                hold_writes;
  logic                hold_reads;

  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] busy_view;
  logic [NUM_REGS-1:0] busy_next;
  logic                hazard;
  logic                accept;
  logic                drain_done;

  assign hold_op     = hold[31:27];
  assign hold_rd     = hold[26:23];
  assign hold_rs1    = hold[22:19];
  assign hold_rs2    = hold[18:15];
  assign hold_writes = writes_rd(hold_op);
  assign hold_reads  = reads_rs(hold_op);

  assign accept      = (state == S_ISSUE) && issue_ready;

  // Writeback clear mask for this cycle.
  always_comb begin
    clr_mask = '0;
    if (wb_valid) clr_mask[wb_addr] = 1'b1;
  end

  // Scoreboard set mask: only an accepted issue creates a new writer.
  always_comb begin
    set_mask = '0;
    if (accept && hold_writes) set_mask[hold_rd] = 1'b1;
  end

  // The view of the scoreboard used for hazard and drain decisions.
`ifdef SB_WB_BYPASS_EN
  assign busy_view = busy & ~clr_mask;
`else
  assign busy_view = busy;
`endif

  assign hazard = (hold_reads && (busy_view[hold_rs1] || busy_view[hold_rs2])) ||
                  (hold_writes && busy_view[hold_rd]);
  assign drain_done = (busy_view == '0);

  // Clear first, then set, so a new writer wins over a same-cycle clear.
  assign busy_next = (busy & ~clr_mask) | set_mask;

  // Next-state decode for the issue FSM.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (instr_valid) state_next = S_CHECK;
      S_CHECK: if (!hazard) state_next = S_ISSUE;
      S_ISSUE: if (issue_ready) state_next = (hold_op == OP_STOP) ? S_DRAIN : S_IDLE;
      S_DRAIN: if (drain_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state and instruction hold register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      hold  <= '0;
    end else begin
      state <= state_next;
      if ((state == S_IDLE) && instr_valid) hold <= instr;
    end
  end

  // Scoreboard and spurious-writeback flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      wb_spurious <= 1'b0;
    end else begin
      busy        <= busy_next;
      wb_spurious <= wb_valid && !busy[wb_addr];
    end
  end

  // Saturating count of CHECK cycles lost to hazards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == S_CHECK) && hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign instr_ready = (state == S_IDLE);
  assign issue_valid = (state == S_ISSUE);
  assign issue_instr = hold;
  assign busy_map    = busy;
  assign fsm_state   = state;

endmodule

// File: tb/tb_id_issue_scoreboard.sv
// tb_id_issue_scoreboard: directed and randomized checks of
// id_issue_scoreboard against a behavioural scoreboard model.
module tb_id_issue_scoreboard;

  localparam logic [4:0] OP_MOV  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_STOP = 5'd13;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic        issue_ready;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] busy_map;
  logic [15:0] stall_cnt;
  logic        wb_spurious;
  logic [1:0]  fsm_state;

  int n_tests;
  int n_fail;

  id_issue_scoreboard #(.NUM_REGS(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .busy_map(busy_map), .stall_cnt(stall_cnt), .wb_spurious(wb_spurious),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  typedef enum int {P_WAIT, P_CHECK, P_OFFER, P_DRAIN} phase_t;
  phase_t      m_phase;
  bit          m_busy[16];
  logic [31:0] m_hold;
  int unsigned m_stall;
  bit          m_spur;
  logic [31:0] exp_q[$];

  function automatic bit f_writes(input logic [4:0] op);
    return op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd8};
  endfunction

  function automatic bit f_reads(input logic [4:0] op);
    return op inside {[5'd0:5'd10]};
  endfunction

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 15'h0};
  endfunction

  task automatic model_reset();
    m_phase = P_WAIT;
    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    m_hold  = '0;
    m_stall = 0;
    m_spur  = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit          seen[16];
    bit          nb[16];
    bit          conflict;
    bit          any_busy;
    logic [4:0]  op;
    op = m_hold[31:27];
    for (int i = 0; i < 16; i++) begin
      seen[i] = m_busy[i];
      nb[i]   = m_busy[i];
    end
`ifdef SB_WB_BYPASS_EN
    if (wb_valid) seen[wb_addr] = 1'b0;
`endif
    if (wb_valid) nb[wb_addr] = 1'b0;
    case (m_phase)
      P_WAIT: if (instr_valid) begin
        m_hold  = instr;
        m_phase = P_CHECK;
      end
      P_CHECK: begin
        conflict = (f_reads(op) && (seen[m_hold[22:19]] || seen[m_hold[18:15]])) ||
                   (f_writes(op) && seen[m_hold[26:23]]);
        if (conflict) begin
          if (m_stall < 65535) m_stall++;
        end else begin
          m_phase = P_OFFER;
        end
      end
      P_OFFER: if (issue_ready) begin
        exp_q.push_back(m_hold);
        if (f_writes(op)) nb[m_hold[26:23]] = 1'b1;
        m_phase = (op == OP_STOP) ? P_DRAIN : P_WAIT;
      end
      P_DRAIN: begin
        any_busy = 1'b0;
        for (int i = 0; i < 16; i++) any_busy |= seen[i];
        if (!any_busy) m_phase = P_WAIT;
      end
      default: m_phase = P_WAIT;
    endcase
    m_spur = wb_valid && !m_busy[wb_addr];
    for (int i = 0; i < 16; i++) m_busy[i] = nb[i];
  endtask

  // ---------------- scoreboard / checks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    check("instr_ready", instr_ready, (m_phase == P_WAIT));
    check("issue_valid", issue_valid, (m_phase == P_OFFER));
    check("issue_instr", issue_instr, m_hold);
    check("busy_map", busy_map, m_busy_vec());
    check("stall_cnt", stall_cnt, m_stall);
    check("wb_spurious", wb_spurious, m_spur);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    if (issue_valid && issue_ready) begin
      check("accept_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("accepted_instr", issue_instr, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    instr_valid = 1'b0; instr = '0; issue_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wb(input logic [3:0] addr);
    wb_valid = 1'b1; wb_addr = addr;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic issue_one(input logic [4:0] op, input logic [3:0] rd,
                           input logic [3:0] rs1, input logic [3:0] rs2);
    int n;
    n = 0;
    issue_ready = 1'b1;
    instr_valid = 1'b1; instr = mk(op, rd, rs1, rs2);
    tick();
    instr_valid = 1'b0;
    while (!issue_valid && n < 20) begin
      tick();
      n++;
    end
    check("issue_one_bound", n < 20, 1);
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_instr_ready"}, instr_ready, 1);
    check({tag, "_issue_valid"}, issue_valid, 0);
    check({tag, "_issue_instr"}, issue_instr, 0);
    check({tag, "_busy_map"}, busy_map, 0);
    check({tag, "_stall_cnt"}, stall_cnt, 0);
    check({tag, "_wb_spurious"}, wb_spurious, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_list[$];
    n_tests = 0;
    n_fail  = 0;

    // Reset values.
    do_reset();
    check_reset_values("reset");

    // ADD r1,r2,r3: offered two cycles after being presented, then r1 busy.
    instr_valid = 1'b1; instr = mk(OP_ADD, 4'd1, 4'd2, 4'd3);
    tick();
    instr_valid = 1'b0;
    check("add_not_yet_valid", issue_valid, 0);
    tick();
    check("add_valid", issue_valid, 1);
    check("add_instr", issue_instr, mk(OP_ADD, 4'd1, 4'd2, 4'd3));
    tick();
    check("add_busy", busy_map, 16'h0002);
    check("add_stall", stall_cnt, 0);
    check("add_ready_again", instr_ready, 1);

    // SUB r4,r1,r5 waits on r1; writeback arrives in the 5th cycle.
    instr_valid = 1'b1; instr = mk(OP_SUB, 4'd4, 4'd1, 4'd5);
    tick();
    instr_valid = 1'b0;
    repeat (4) begin
      tick();
      check("sub_stalled", issue_valid, 0);
    end
    wb(4'd1);
`ifdef SB_WB_BYPASS_EN
    check("sub_issue_bypass", issue_valid, 1);
    check("sub_stall_bypass", stall_cnt, 4);
`else
    check("sub_issue_late", issue_valid, 0);
    tick();
    check("sub_issue_nobypass", issue_valid, 1);
    check("sub_stall_nobypass", stall_cnt, 5);
`endif
    tick();
    check("sub_busy", busy_map, 16'h0010);

    // Hazard-free MOV r6 held under backpressure for 4 cycles.
    issue_ready = 1'b0;
    instr_valid = 1'b1; instr = mk(OP_MOV, 4'd6, 4'd0, 4'd0);
    tick();
    instr_valid = 1'b0;
    tick();
    repeat (4) begin
      tick();
      check("hold_valid", issue_valid, 1);
      check("hold_instr", issue_instr, mk(OP_MOV, 4'd6, 4'd0, 4'd0));
      check("hold_instr_ready", instr_ready, 0);
      check("hold_busy", busy_map, 16'h0010);
    end
    issue_ready = 1'b1;
    tick();
    check("hold_accept_busy", busy_map, 16'h0050);
    wb(4'd4);
    wb(4'd6);
    check("clean_busy", busy_map, 16'h0000);

    // STOP drains r2 and r7 before accepting anything new.
    issue_one(OP_ADD, 4'd2, 4'd0, 4'd0);
    issue_one(OP_ADD, 4'd7, 4'd0, 4'd0);
    check("drain_setup_busy", busy_map, 16'h0084);
    issue_one(OP_STOP, 4'd0, 4'd0, 4'd0);
    check("drain_blocked0", instr_ready, 0);
    repeat (3) begin
      tick();
      check("drain_blocked", instr_ready, 0);
    end
    wb(4'd2);
    check("drain_after_first_wb", instr_ready, 0);
    wb(4'd7);
`ifdef SB_WB_BYPASS_EN
    check("drain_exit_bypass", instr_ready, 1);
`else
    check("drain_exit_wait", instr_ready, 0);
    tick();
    check("drain_exit_nobypass", instr_ready, 1);
`endif

    // Accept of MOV r3 in the same cycle as a writeback to r3: set wins.
    issue_one(OP_ADD, 4'd3, 4'd0, 4'd0);
    instr_valid = 1'b1; instr = mk(OP_MOV, 4'd3, 4'd0, 4'd0);
    tick();
    instr_valid = 1'b0;
    tick();
    wb(4'd3);
    if (!issue_valid) tick();
    check("mov3_offered", issue_valid, 1);
    wb_valid = 1'b1; wb_addr = 4'd3;
    tick();
    wb_valid = 1'b0;
    check("mov3_set_wins", busy_map[3], 1);
    tick();
    // Writeback to idle r9: one spurious pulse, scoreboard unchanged.
    wb(4'd9);
    check("spur_pulse", wb_spurious, 1);
    check("spur_busy", busy_map, 16'h0008);
    tick();
    check("spur_one_cycle", wb_spurious, 0);
    wb(4'd3);

    // Asynchronous reset while stalled in CHECK with 7 lost cycles.
    do_reset();
    issue_one(OP_ADD, 4'd5, 4'd0, 4'd0);
    instr_valid = 1'b1; instr = mk(OP_SUB, 4'd1, 4'd5, 4'd0);
    tick();
    instr_valid = 1'b0;
    repeat (7) tick();
    check("pre_reset_stall", stall_cnt, 7);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    #2;
    reset = 1'b0;
    model_reset();
    issue_one(OP_ADD, 4'd1, 4'd2, 4'd3);
    check("post_reset_busy", busy_map, 16'h0002);
    wb(4'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      instr_valid = ($urandom_range(0, 9) < 6);
      instr = $urandom();
      if ($urandom_range(0, 9) == 0) instr[31:27] = OP_STOP;
      else if ($urandom_range(0, 3) != 0) instr[31:27] = 5'($urandom_range(0, 14));
      issue_ready = ($urandom_range(0, 9) < 7);
      wb_valid = ($urandom_range(0, 9) < 4);
      busy_list.delete();
      for (int i = 0; i < 16; i++) if (m_busy[i]) busy_list.push_back(i);
      if (busy_list.size() != 0 && $urandom_range(0, 3) != 0)
        wb_addr = 4'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        wb_addr = 4'($urandom_range(0, 15));
      tick();
    end
    instr_valid = 1'b0;
    wb_valid = 1'b0;
    issue_ready = 1'b1;
    for (int i = 0; i < 16; i++) wb(4'(i));
    repeat (4) tick();
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
